ifu: RTL and testbench

//  Instruction fetch unit; producer end of the insn/valid interface consumed by the decode stage.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 56 +++++
 rtl/ifu.sv | 131 +++++++++++++
 tb/tb_ifu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, reset vector, fetch-buffer entry type and PC helpers for the ifu.
package ifu_pkg;
    localparam int PC_W   = 64;
    localparam int INSN_W = 32;

    localparam logic [PC_W-1:0] RESET_VECTOR   = 64'h8000_0000;
    localparam logic [PC_W-1:0] ALIGN_MASK     = ~64'h3;
    localparam logic [3:0]      CAUSE_MISALIGN = 4'd0;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction
endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count.
module ifu_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;

    // Explicit wrap so DEPTH need not be a power of two (pc queue uses MAX_OUTST).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full));
        end
    end
endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, credit-limited imem issue, in-order buffer, redirect/drop.
// Optional misaligned-redirect exception and issue stall under IFU_MISALIGN_CHK_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [INSN_W-1:0] i_imem_rdata,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INSN_W-1:0] o_insn,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_exc_misalign
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTST + 1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic [FCW-1:0]  fifo_cnt;
    logic            fifo_empty;
    logic            stall;
    logic            credit;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [PC_W-1:0] issue_pc;
    logic [OW-1:0]   pcq_cnt;
    logic            pcq_empty;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign;

    assign target = i_redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (i_redirect) begin
            misalign <= (i_redirect_pc[1:0] != 2'b00);
        end
    end

    assign stall          = misalign;
    assign o_exc_misalign = misalign;
`else
    assign target         = i_redirect_pc & ALIGN_MASK;
    assign stall          = 1'b0;
    assign o_exc_misalign = 1'b0;
`endif

    // Buffered plus in-flight words never exceed buffer capacity, so a push always has room.
    assign credit      = (int'(fifo_cnt) + int'(outst) < FIFO_DEPTH) && (int'(outst) < MAX_OUTST);
    assign o_imem_req  = ~rst & ~i_redirect & ~stall & credit;
    assign o_imem_addr = pc;
    assign issue       = o_imem_req & i_imem_gnt;

    assign push       = i_imem_rvalid & (drop == '0) & ~i_redirect;
    assign push_entry = '{insn: i_imem_rdata, pc: issue_pc};
    assign o_valid    = ~rst & ~fifo_empty;
    assign pop        = o_valid & i_ready & ~i_redirect;
    assign o_insn     = o_valid ? head.insn : '0;
    assign o_pc       = o_valid ? head.pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else begin
            outst <= outst + OW'(issue) - OW'(i_imem_rvalid);
            if (i_redirect) begin
                pc   <= target;
                drop <= outst - OW'(i_imem_rvalid);
            end else begin
                if (issue) begin
                    pc <= pc_next(pc);
                end
                if (i_imem_rvalid && drop != '0) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_insn_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect),
        .din   (push_entry),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Every response retires the oldest in-flight PC, even when the word itself is dropped.
    ifu_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUTST)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (i_imem_rvalid),
        .flush (1'b0),
        .din   (pc),
        .dout  (issue_pc),
        .empty (pcq_empty),
        .count (pcq_cnt)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (!i_imem_rvalid || !pcq_empty);
            assert (pcq_cnt == outst);
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed table-driven and hand-sequenced checks for ifu.
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] insn;
    logic [63:0] pc;
    logic        exc_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        gnt;
        logic        rdy;
        logic        ereq;
        logic [63:0] eaddr;
        logic        evalid;
        logic [31:0] einsn;
        logic [63:0] epc;
    } vec_t;

    vec_t tbl[$];

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_gnt     (imem_gnt),
        .i_imem_rvalid  (imem_rvalid),
        .i_imem_rdata   (imem_rdata),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_insn         (insn),
        .o_pc           (pc),
        .o_exc_misalign (exc_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rv, input logic [31:0] rd, input logic gnt, input logic rdy,
                                 input logic ereq, input logic [63:0] eaddr, input logic evalid,
                                 input logic [31:0] einsn, input logic [63:0] epc);
        vec_t v;
        v.rv = rv; v.rd = rd; v.gnt = gnt; v.rdy = rdy; v.ereq = ereq; v.eaddr = eaddr;
        v.evalid = evalid; v.einsn = einsn; v.epc = epc;
        return v;
    endfunction

    task automatic step(input string nm, input logic rv, input logic [31:0] rd, input logic gnt,
                        input logic redir, input logic [63:0] rpc, input logic rdy,
                        input logic ereq, input logic [63:0] eaddr, input logic evalid,
                        input logic [31:0] einsn, input logic [63:0] epc, input logic eexc);
        @(negedge clk);
        imem_rvalid = rv;
        imem_rdata  = rd;
        imem_gnt    = gnt;
        redirect    = redir;
        redirect_pc = rpc;
        ready       = rdy;
        #1;
        chk({nm, " req"}, {63'd0, imem_req}, {63'd0, ereq});
        if (ereq) chk({nm, " addr"}, imem_addr, eaddr);
        chk({nm, " valid"}, {63'd0, valid}, {63'd0, evalid});
        if (evalid) begin
            chk({nm, " insn"}, {32'd0, insn}, {32'd0, einsn});
            chk({nm, " pc"}, pc, epc);
        end
        chk({nm, " exc"}, {63'd0, exc_misalign}, {63'd0, eexc});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; imem_gnt = 1'b0;
        redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst req", {63'd0, imem_req}, 64'd0);
        chk("rst valid", {63'd0, valid}, 64'd0);
        chk("rst insn", {32'd0, insn}, 64'd0);
        chk("rst pc", pc, 64'd0);
        chk("rst exc", {63'd0, exc_misalign}, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic        mreq;
        logic        mexc;
        logic [63:0] maddr;

        // In-order streaming, then ready=0 fills exactly 4 entries and drains without loss.
        tbl.push_back(mkv(0, 32'h0,        1, 1, 1, 64'h8000_0000, 0, 32'h0,        64'h0));
        tbl.push_back(mkv(1, 32'h1111_0000, 1, 1, 1, 64'h8000_0004, 0, 32'h0,        64'h0));
        tbl.push_back(mkv(1, 32'h1111_0001, 1, 1, 1, 64'h8000_0008, 1, 32'h1111_0000, 64'h8000_0000));
        tbl.push_back(mkv(1, 32'h1111_0002, 1, 1, 1, 64'h8000_000c, 1, 32'h1111_0001, 64'h8000_0004));
        tbl.push_back(mkv(0, 32'h0,        0, 1, 1, 64'h8000_0010, 1, 32'h1111_0002, 64'h8000_0008));
        tbl.push_back(mkv(1, 32'h1111_0003, 0, 1, 1, 64'h8000_0010, 0, 32'h0,        64'h0));
        tbl.push_back(mkv(0, 32'h0,        0, 1, 1, 64'h8000_0010, 1, 32'h1111_0003, 64'h8000_000c));
        tbl.push_back(mkv(0, 32'h0,        1, 0, 1, 64'h8000_0010, 0, 32'h0,        64'h0));
        tbl.push_back(mkv(1, 32'h2222_0004, 1, 0, 1, 64'h8000_0014, 0, 32'h0,        64'h0));
        tbl.push_back(mkv(1, 32'h2222_0005, 1, 0, 1, 64'h8000_0018, 1, 32'h2222_0004, 64'h8000_0010));
        tbl.push_back(mkv(1, 32'h2222_0006, 1, 0, 1, 64'h8000_001c, 1, 32'h2222_0004, 64'h8000_0010));
        tbl.push_back(mkv(1, 32'h2222_0007, 1, 0, 0, 64'h0,        1, 32'h2222_0004, 64'h8000_0010));
        tbl.push_back(mkv(0, 32'h0,        1, 0, 0, 64'h0,        1, 32'h2222_0004, 64'h8000_0010));
        tbl.push_back(mkv(0, 32'h0,        1, 1, 0, 64'h0,        1, 32'h2222_0004, 64'h8000_0010));
        tbl.push_back(mkv(0, 32'h0,        1, 1, 1, 64'h8000_0020, 1, 32'h2222_0005, 64'h8000_0014));
        tbl.push_back(mkv(1, 32'h2222_0008, 0, 1, 1, 64'h8000_0024, 1, 32'h2222_0006, 64'h8000_0018));
        tbl.push_back(mkv(0, 32'h0,        0, 1, 1, 64'h8000_0024, 1, 32'h2222_0007, 64'h8000_001c));
        tbl.push_back(mkv(0, 32'h0,        0, 1, 1, 64'h8000_0024, 1, 32'h2222_0008, 64'h8000_0020));
        tbl.push_back(mkv(0, 32'h0,        0, 1, 1, 64'h8000_0024, 0, 32'h0,        64'h0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rd, tbl[i].gnt, 1'b0, 64'h0, tbl[i].rdy,
                 tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid, tbl[i].einsn, tbl[i].epc, 1'b0);
        end

        // Two outstanding, redirect: both late words dropped.
        step("rd0", 0, 0, 1, 0, 0, 1, 1, 64'h8000_0024, 0, 0, 0, 0);
        step("rd1", 0, 0, 1, 0, 0, 1, 1, 64'h8000_0028, 0, 0, 0, 0);
        step("rd2", 0, 0, 1, 1, 64'h8000_1000, 1, 0, 0, 0, 0, 0, 0);
        step("rd3", 1, 32'hdead_0001, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rd4", 1, 32'hdead_0002, 1, 0, 0, 1, 1, 64'h8000_1000, 0, 0, 0, 0);
        step("rd5", 1, 32'h3333_0009, 0, 0, 0, 1, 1, 64'h8000_1004, 0, 0, 0, 0);
        step("rd6", 0, 0, 0, 0, 0, 1, 1, 64'h8000_1004, 1, 32'h3333_0009, 64'h8000_1000, 0);
        step("rd7", 0, 0, 0, 0, 0, 1, 1, 64'h8000_1004, 0, 0, 0, 0);

        // Redirect coincident with rvalid and pop: word discarded, buffer flushed, no stale drop.
        step("rp0", 0, 0, 1, 0, 0, 1, 1, 64'h8000_1004, 0, 0, 0, 0);
        step("rp1", 1, 32'h4444_000a, 1, 0, 0, 1, 1, 64'h8000_1008, 0, 0, 0, 0);
        step("rp2", 1, 32'hdead_0003, 1, 1, 64'h8000_2000, 1, 0, 0, 1, 32'h4444_000a, 64'h8000_1004, 0);
        step("rp3", 0, 0, 0, 0, 0, 1, 1, 64'h8000_2000, 0, 0, 0, 0);
        step("rp4", 0, 0, 1, 0, 0, 1, 1, 64'h8000_2000, 0, 0, 0, 0);
        step("rp5", 1, 32'h4444_000c, 0, 0, 0, 1, 1, 64'h8000_2004, 0, 0, 0, 0);
        step("rp6", 0, 0, 0, 0, 0, 1, 1, 64'h8000_2004, 1, 32'h4444_000c, 64'h8000_2000, 0);
        step("rp7", 0, 0, 0, 0, 0, 1, 1, 64'h8000_2004, 0, 0, 0, 0);

        // Grant withheld: address stable, nothing delivered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i), 0, 0, 0, 0, 0, 1, 1, 64'h8000_0000, 0, 0, 0, 0);
        end
        step("hold_gnt", 0, 0, 1, 0, 0, 1, 1, 64'h8000_0000, 0, 0, 0, 0);
        step("hold_nxt", 0, 0, 0, 0, 0, 1, 1, 64'h8000_0004, 0, 0, 0, 0);

        // Misaligned redirect, back-to-back redirects, 64-bit PC wrap.
        do_reset();
`ifdef IFU_MISALIGN_CHK_EN
        mreq = 1'b0; mexc = 1'b1; maddr = 64'h8000_0002;
`else
        mreq = 1'b1; mexc = 1'b0; maddr = 64'h8000_0000;
`endif
        step("mis0", 0, 0, 0, 1, 64'h8000_0002, 1, 0, 0, 0, 0, 0, 0);
        step("mis1", 0, 0, 0, 0, 0, 1, mreq, maddr, 0, 0, 0, mexc);
        chk("mis1 pc", imem_addr, maddr);
        step("b2b0", 0, 0, 0, 1, 64'h9000_0000, 1, 0, 0, 0, 0, 0, mexc);
        step("b2b1", 0, 0, 0, 1, 64'ha000_0000, 1, 0, 0, 0, 0, 0, 0);
        step("b2b2", 0, 0, 0, 0, 0, 1, 1, 64'ha000_0000, 0, 0, 0, 0);
        step("wrap0", 0, 0, 0, 1, 64'hffff_ffff_ffff_fffc, 1, 0, 0, 0, 0, 0, 0);
        step("wrap1", 0, 0, 1, 0, 0, 1, 1, 64'hffff_ffff_ffff_fffc, 0, 0, 0, 0);
        step("wrap2", 0, 0, 0, 0, 0, 1, 1, 64'h0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
